// File: rtl/arch_state_dump.sv
// Architectural state dump engine: walks GPRs REG_FIRST..REG_LAST, then HI and LO,
// streaming tagged words over valid/ready. Define DUMP_CHECKSUM_EN to append an XOR checksum word (tag 34).
module arch_state_dump #(
  parameter int REG_FIRST = 1,
  parameter int REG_LAST  = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [4:0]        rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [5:0]        out_tag_o,
  output logic [DATA_W-1:0] out_data_o
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [5:0] FIRST  = 6'(REG_FIRST);
  localparam logic [5:0] LAST   = 6'(REG_LAST);
  localparam logic [5:0] TAG_HI = 6'd32;
  localparam logic [5:0] TAG_LO = 6'd33;
  localparam logic [5:0] TAG_CK = 6'd34;

  state_t            state, state_nx;
  logic [5:0]        idx, idx_nx;
  logic [5:0]        tag_nx;
  logic [DATA_W-1:0] data_nx;
  logic              accept;

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign out_valid_o = (state == SEND);
  assign accept      = out_valid_o && out_ready_i;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;

  // Running XOR of every accepted word; the checksum word is emitted before it folds itself in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          acc <= '0;
    else if (state == IDLE && start_i) acc <= '0;
    else if (accept)                   acc <= acc ^ out_data_o;
  end
`endif

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    tag_nx    = out_tag_o;
    data_nx   = out_data_o;
    rd_en_o   = 1'b0;
    rd_addr_o = 5'd0;
    case (state)
      IDLE: if (start_i) begin
        state_nx = READ;
        idx_nx   = FIRST;
      end
      READ: begin
        state_nx = SEND;
        tag_nx   = idx;
        if (idx == TAG_HI)      data_nx = hi_i;
        else if (idx == TAG_LO) data_nx = lo_i;
        else begin
          rd_en_o   = 1'b1;
          rd_addr_o = idx[4:0];
          data_nx   = rd_data_i;
        end
      end
      SEND: if (out_ready_i) begin
        if (idx == TAG_LO) begin
`ifdef DUMP_CHECKSUM_EN
          idx_nx  = TAG_CK;
          tag_nx  = TAG_CK;
          data_nx = acc ^ out_data_o;
`else
          state_nx = DONE;
`endif
        end else if (idx == TAG_CK) begin
          state_nx = DONE;
        end else begin
          state_nx = READ;
          idx_nx   = (idx == LAST) ? TAG_HI : idx + 6'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= FIRST;
      out_tag_o  <= '0;
      out_data_o <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      out_tag_o  <= tag_nx;
      out_data_o <= data_nx;
    end
  end

endmodule
